// File: rtl/q_vec_pkg.sv
// rtl/q_vec_pkg.sv - shared constants, vector table and FSM encoding for q_vector_driver
package q_vec_pkg;

    localparam int W     = 3;
    localparam int DEPTH = 4;

    // One self-test vector: operands driven to Q and the result Q must return.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } q_vec_t;

    // Expected values are (a + b) mod 2^W.
    localparam q_vec_t VEC_TABLE [DEPTH] = '{
        '{a: 3'd5, b: 3'd2, exp: 3'd7},
        '{a: 3'd7, b: 3'd3, exp: 3'd2},
        '{a: 3'd0, b: 3'd2, exp: 3'd2},
        '{a: 3'd1, b: 3'd1, exp: 3'd2}
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/q_vector_driver.sv
// rtl/q_vector_driver.sv - built-in self-test initiator that drives Q and checks its result
module q_vector_driver
    import q_vec_pkg::*;
#(
    parameter int  LAT = 1,
    localparam int EW  = $clog2(DEPTH + 1),
    localparam int IW  = $clog2(DEPTH),
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [W-1:0]  a_out,
    output logic [W-1:0]  b_out,
    output logic          op_valid,
    input  logic [W-1:0]  f_in,
    output logic          busy,
    output logic          done,
    output logic [EW-1:0] err_count,
    output logic          pass,
    output logic [IW-1:0] vec_idx
);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [EW-1:0] err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_hold_q, a_hold_d;
    logic [W-1:0]  b_hold_q, b_hold_d;
    q_vec_t        cur;

    assign cur = VEC_TABLE[idx_q];

    // State and datapath registers; reset clears every visible result at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            a_hold_q <= a_hold_d;
            b_hold_q <= b_hold_d;
        end
    end

    // Sequencing: issue one vector, wait LAT cycles for Q, check, advance.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        a_hold_d = a_hold_q;
        b_hold_d = b_hold_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    err_d   = '0;
                end
            end
            ST_ISSUE: begin
                // Operands are captured so they stay stable while Q computes.
                a_hold_d = cur.a;
                b_hold_d = cur.b;
                cnt_d    = CW'(LAT - 1);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CHECK: begin
                if ((f_in != cur.exp) && (err_q != EW'(DEPTH))) begin
                    err_d = err_q + EW'(1);
                end
                if (idx_q == IW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // During ISSUE the table entry goes straight out so op_valid and operands align.
    assign a_out     = (state_q == ST_ISSUE) ? cur.a : a_hold_q;
    assign b_out     = (state_q == ST_ISSUE) ? cur.b : b_hold_q;
    assign op_valid  = (state_q == ST_ISSUE);
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign err_count = err_q;
    assign pass      = done && (err_q == '0);
    assign vec_idx   = idx_q;

endmodule

// File: tb/tb_q_vector_driver.sv
// tb/tb_q_vector_driver.sv - randomized self-checking bench for q_vector_driver
module tb_q_vector_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic [2:0] f1, f3;
    logic [2:0] a1, b1, a3, b3;
    logic       ov1, ov3, busy1, busy3, done1, done3, pass1, pass3;
    logic [2:0] err1, err3;
    logic [1:0] idx1, idx3;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side copy of the vector operands; expected sums are derived from them.
    int ta [4] = '{5, 7, 0, 1};
    int tb [4] = '{2, 3, 2, 1};

    // Fault-injection configuration for the modelled Q.
    logic       sel;
    logic [3:0] mask;
    logic       use_xor;
    logic [2:0] fv, xv;
    logic [1:0] cur_vec;

    always #5 clk = ~clk;

    q_vector_driver #(.LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a_out(a1), .b_out(b1),
        .op_valid(ov1), .f_in(f1), .busy(busy1), .done(done1),
        .err_count(err1), .pass(pass1), .vec_idx(idx1)
    );

    q_vector_driver #(.LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .a_out(a3), .b_out(b3),
        .op_valid(ov3), .f_in(f3), .busy(busy3), .done(done3),
        .err_count(err3), .pass(pass3), .vec_idx(idx3)
    );

    // Ideal Q: a 3-bit adder with a LAT-deep register pipeline.
    logic [2:0] p1;
    logic [2:0] p3 [3];
    always @(posedge clk) begin
        p1    <= a1 + b1;
        p3[0] <= a3 + b3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    always_comb begin
        f1 = p1;
        f3 = p3[2];
        if (mask[cur_vec]) begin
            if (sel == 1'b0) f1 = use_xor ? (p1 ^ xv) : fv;
            else             f3 = use_xor ? (p3[2] ^ xv) : fv;
        end
    end

    logic       o_ov, o_busy, o_done, o_pass;
    logic [2:0] o_a, o_b, o_err;
    logic [1:0] o_idx;
    assign o_ov   = sel ? ov3   : ov1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_pass = sel ? pass3 : pass1;
    assign o_a    = sel ? a3    : a1;
    assign o_b    = sel ? b3    : b1;
    assign o_err  = sel ? err3  : err1;
    assign o_idx  = sel ? idx3  : idx1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        start1 = v && (sel == 1'b0);
        start3 = v && (sel == 1'b1);
    endtask

    // One run: per-cycle expectations from the timing rules; abort_c >= 0 asserts reset there.
    task automatic run_vec(input logic s, input logic [3:0] m, input logic ux,
                           input logic [2:0] f, input logic [2:0] x,
                           input int mid_start, input int abort_c);
        int lat, per, total, errs, k, ph, sum, fk;
        sel = s; mask = m; use_xor = ux; fv = f; xv = x; cur_vec = 2'd0;
        lat   = s ? 3 : 1;
        per   = lat + 2;
        total = 4 * per;
        errs  = 0;
        @(negedge clk);
        drive_start(1'b1);
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            drive_start(c == mid_start);
            if (c == abort_c) begin
                reset = 1'b1;
                #1;
                check("abort_a",     32'(o_a),     0);
                check("abort_b",     32'(o_b),     0);
                check("abort_valid", 32'(o_ov),    0);
                check("abort_busy",  32'(o_busy),  0);
                check("abort_done",  32'(o_done),  0);
                check("abort_err",   32'(o_err),   0);
                check("abort_idx",   32'(o_idx),   0);
                check("abort_pass",  32'(o_pass),  0);
                @(negedge clk);
                drive_start(1'b0);
                reset = 1'b0;
                return;
            end
            if (c < total) begin
                k  = c / per;
                ph = c % per;
                check("op_valid", 32'(o_ov),   32'(ph == 0));
                check("busy",     32'(o_busy), 1);
                check("done_lo",  32'(o_done), 0);
                if (ph == 0) begin
                    cur_vec = 2'(k);
                    check("a_out",   32'(o_a),   32'(ta[k]));
                    check("b_out",   32'(o_b),   32'(tb[k]));
                    check("vec_idx", 32'(o_idx), 32'(k));
                    check("err_run", 32'(o_err), 32'(errs));
                end else begin
                    check("a_hold",  32'(o_a),   32'(ta[k]));
                end
                if (ph == per - 1) begin
                    sum = (ta[k] + tb[k]) % 8;
                    fk  = m[k] ? (ux ? (sum ^ int'(x)) : int'(f)) : sum;
                    if (fk != sum && errs < 4) errs++;
                end
            end else begin
                check("done",      32'(o_done), 1);
                check("busy_end",  32'(o_busy), 0);
                check("valid_end", 32'(o_ov),   0);
                check("err_end",   32'(o_err),  32'(errs));
                check("pass",      32'(o_pass), 32'(errs == 0));
                check("idx_end",   32'(o_idx),  3);
                check("a_end",     32'(o_a),    32'(ta[3]));
                check("b_end",     32'(o_b),    32'(tb[3]));
            end
        end
        drive_start(1'b0);
    endtask

    initial begin
        logic r_s;
        reset = 1'b1; sel = 1'b0; mask = 4'd0; use_xor = 1'b0;
        fv = 3'd0; xv = 3'd1; cur_vec = 2'd0;
        start1 = 1'b0; start3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state1", 32'({a1, b1, ov1, busy1, done1, err1, pass1, idx1}), 0);
        check("rst_state3", 32'({a3, b3, ov3, busy3, done3, err3, pass3, idx3}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_stays", 32'({ov1, busy1, done1}), 0);

        run_vec(1'b0, 4'b0000, 1'b0, 3'd0, 3'd1, -1, -1);
        run_vec(1'b0, 4'b0010, 1'b0, 3'd0, 3'd1, -1, -1);
        run_vec(1'b0, 4'b1111, 1'b0, 3'd7, 3'd1, -1, -1);
        run_vec(1'b0, 4'b1111, 1'b1, 3'd0, 3'd5, -1, -1);
        run_vec(1'b1, 4'b0000, 1'b0, 3'd0, 3'd1, -1, -1);
        run_vec(1'b0, 4'b0000, 1'b0, 3'd0, 3'd1, 7, -1);
        run_vec(1'b0, 4'b1011, 1'b1, 3'd0, 3'd3, -1, -1);
        run_vec(1'b0, 4'b0000, 1'b0, 3'd0, 3'd1, -1, -1);
        run_vec(1'b0, 4'b0101, 1'b1, 3'd0, 3'd2, -1, 7);
        run_vec(1'b0, 4'b0000, 1'b0, 3'd0, 3'd1, -1, -1);
        run_vec(1'b1, 4'b0100, 1'b1, 3'd0, 3'd6, 12, -1);

        for (int i = 0; i < 12; i++) begin
            r_s = 1'($urandom_range(0, 1));
            run_vec(r_s, 4'($urandom), 1'($urandom), 3'($urandom),
                    3'($urandom_range(1, 7)), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
